// File: rtl/simple_alu_issue_stage_if.sv
// Bundles the dispatch, ALU and writeback signals of the ALU issue stage.
// The slave modport is the issue stage; master is whoever drives the dispatcher, ALU and writeback side.
interface simple_alu_issue_stage_if #(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4
);
  logic                       Flush;
  logic                       InstructionValid;
  logic                       InstructionReady;
  logic [3:0]                 MinorOpcode;
  logic [DATABITWIDTH-1:0]    OperandAData;
  logic [DATABITWIDTH-1:0]    OperandBData;
  logic [REGADDRBITWIDTH-1:0] DestRegAddr;
  logic [3:0]                 AluMinorOpcode;
  logic [DATABITWIDTH-1:0]    AluOperandAData;
  logic [DATABITWIDTH-1:0]    AluOperandBData;
  logic [DATABITWIDTH-1:0]    AluResultIn;
  logic                       WritebackValid;
  logic                       WritebackAck;
  logic [REGADDRBITWIDTH-1:0] WritebackRegAddr;
  logic [DATABITWIDTH-1:0]    WritebackData;
  logic [1:0]                 InFlightCount;

  modport slave (
    input  Flush, InstructionValid, MinorOpcode, OperandAData, OperandBData, DestRegAddr,
           AluResultIn, WritebackAck,
    output InstructionReady, AluMinorOpcode, AluOperandAData, AluOperandBData,
           WritebackValid, WritebackRegAddr, WritebackData, InFlightCount
  );

  modport master (
    output Flush, InstructionValid, MinorOpcode, OperandAData, OperandBData, DestRegAddr,
           AluResultIn, WritebackAck,
    input  InstructionReady, AluMinorOpcode, AluOperandAData, AluOperandBData,
           WritebackValid, WritebackRegAddr, WritebackData, InFlightCount
  );
endinterface

// File: rtl/simple_alu_issue_stage.sv
// Two-stage ALU issue pipeline: S1 holds operands driving the external ALU,
// S2 holds the captured result until writeback acknowledges it.
module simple_alu_issue_stage #(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4
) (
  input  logic                      clk,
  input  logic                      sync_rst,
  simple_alu_issue_stage_if.slave   bus
);

  logic                       s1Valid;
  logic [3:0]                 s1Opcode;
  logic [DATABITWIDTH-1:0]    s1OperandA;
  logic [DATABITWIDTH-1:0]    s1OperandB;
  logic [REGADDRBITWIDTH-1:0] s1Dest;

  logic                       s2Valid;
  logic [REGADDRBITWIDTH-1:0] s2Dest;
  logic [DATABITWIDTH-1:0]    s2Data;

  logic s2Free;
  logic advance;
  logic instrReady;
  logic accept;
  logic retire;
  logic destLive;

  always_comb begin
    s2Free     = !s2Valid || bus.WritebackAck;
    advance    = s1Valid && s2Free;
    instrReady = !bus.Flush && (!s1Valid || s2Free);
    accept     = bus.InstructionValid && instrReady;
    retire     = s2Valid && bus.WritebackAck;
    destLive   = (s1Dest != '0);
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      s1Valid    <= 1'b0;
      s1Opcode   <= '0;
      s1OperandA <= '0;
      s1OperandB <= '0;
      s1Dest     <= '0;
    end else if (bus.Flush) begin
      s1Valid <= 1'b0;
    end else if (accept) begin
      s1Valid    <= 1'b1;
      s1Opcode   <= bus.MinorOpcode;
      s1OperandA <= bus.OperandAData;
      s1OperandB <= bus.OperandBData;
      s1Dest     <= bus.DestRegAddr;
    end else if (advance) begin
      s1Valid <= 1'b0;
    end
  end

  // Writes to register 0 leave S1 but never reach S2; a concurrent retire still clears S2.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      s2Valid <= 1'b0;
      s2Dest  <= '0;
      s2Data  <= '0;
    end else if (bus.Flush) begin
      s2Valid <= 1'b0;
    end else if (advance && destLive) begin
      s2Valid <= 1'b1;
      s2Dest  <= s1Dest;
      s2Data  <= bus.AluResultIn;
    end else if (retire) begin
      s2Valid <= 1'b0;
    end
  end

  assign bus.InstructionReady = instrReady;
  assign bus.AluMinorOpcode   = s1Opcode;
  assign bus.AluOperandAData  = s1OperandA;
  assign bus.AluOperandBData  = s1OperandB;
  assign bus.WritebackValid   = s2Valid;
  assign bus.WritebackRegAddr = s2Dest;
  assign bus.WritebackData    = s2Data;
  assign bus.InFlightCount    = {1'b0, s1Valid} + {1'b0, s2Valid};

endmodule

// File: tb/tb_simple_alu_issue_stage.sv
// Scoreboard bench for the ALU issue stage: accepted instructions push their expected
// writeback into a queue, a negedge monitor pops and compares on every retire.
module tb_simple_alu_issue_stage;
  localparam int DW = 16;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic sync_rst = 1'b1;
  always #5 clk = ~clk;

  simple_alu_issue_stage_if #(.DATABITWIDTH(DW), .REGADDRBITWIDTH(RW)) bus();

  simple_alu_issue_stage #(.DATABITWIDTH(DW), .REGADDRBITWIDTH(RW)) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .bus      (bus)
  );

  function automatic logic [DW-1:0] aluModel(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    case (op)
      4'h0:    return a + b + 16'd5;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'h5:    return a << b[3:0];
      default: return ~a;
    endcase
  endfunction

  assign bus.AluResultIn = aluModel(bus.AluMinorOpcode, bus.AluOperandAData, bus.AluOperandBData);

  typedef struct packed {
    logic [RW-1:0] dest;
    logic [DW-1:0] data;
  } wb_t;

  wb_t sbQ[$];
  int  errors = 0;
  int  checks = 0;
  int  retireCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each retired result and checks that a stalled result stays put.
  logic          holdPrev = 1'b0;
  logic [RW-1:0] prevAddr;
  logic [DW-1:0] prevData;
  always @(negedge clk) begin
    wb_t exp;
    if (sync_rst === 1'b1 || bus.Flush === 1'b1) begin
      sbQ.delete();
      holdPrev = 1'b0;
    end else begin
      if (holdPrev) begin
        check("wb_hold_valid", 32'(bus.WritebackValid), 32'd1);
        check("wb_hold_addr", 32'(bus.WritebackRegAddr), 32'(prevAddr));
        check("wb_hold_data", 32'(bus.WritebackData), 32'(prevData));
      end
      if (bus.WritebackValid && bus.WritebackAck) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got addr %0h data %0h expected no result at %0t",
                   bus.WritebackRegAddr, bus.WritebackData, $time);
        end else begin
          exp = sbQ.pop_front();
          check("wb_addr", 32'(bus.WritebackRegAddr), 32'(exp.dest));
          check("wb_data", 32'(bus.WritebackData), 32'(exp.data));
        end
        retireCount++;
      end
      holdPrev = bus.WritebackValid && !bus.WritebackAck;
      prevAddr = bus.WritebackRegAddr;
      prevData = bus.WritebackData;
    end
  end

  task automatic sendInstr(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [RW-1:0] d, output int stalls);
    bit accepted = 1'b0;
    stalls = 0;
    bus.InstructionValid = 1'b1;
    bus.MinorOpcode      = op;
    bus.OperandAData     = a;
    bus.OperandBData     = b;
    bus.DestRegAddr      = d;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.InstructionReady && !sync_rst) begin
        if (d != '0) sbQ.push_back('{d, aluModel(op, a, b)});
        accepted = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
    @(posedge clk); #1;
    bus.InstructionValid = 1'b0;
  endtask

  task automatic sendRandom(output int stalls);
    sendInstr(4'($urandom_range(0, 7)), DW'($urandom), DW'($urandom),
              RW'($urandom_range(1, 15)), stalls);
  endtask

  task automatic waitDrain(input int limit);
    bit done = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (sbQ.size() == 0 && bus.InFlightCount == 2'd0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("drain", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int st;
    int base;
    bit pending;
    logic [3:0]    rOp;
    logic [DW-1:0] rA, rB;
    logic [RW-1:0] rD;

    bus.Flush = 1'b0;
    bus.InstructionValid = 1'b0;
    bus.MinorOpcode = '0;
    bus.OperandAData = '0;
    bus.OperandBData = '0;
    bus.DestRegAddr = '0;
    bus.WritebackAck = 1'b0;
    repeat (3) @(posedge clk);
    #1 sync_rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wb_valid", 32'(bus.WritebackValid), 32'd0);
    check("rst_inflight", 32'(bus.InFlightCount), 32'd0);
    check("rst_ready", 32'(bus.InstructionReady), 32'd1);
    check("rst_wb_data", 32'(bus.WritebackData), 32'd0);
    check("rst_wb_addr", 32'(bus.WritebackRegAddr), 32'd0);
    check("rst_alu_a", 32'(bus.AluOperandAData), 32'd0);
    @(posedge clk); #1;

    // Single instruction latency
    sendInstr(4'h0, 16'h0000, 16'h0003, 4'd5, st);
    check("t1_stall", 32'(st), 32'd0);
    @(negedge clk);
    check("t1_inflight_s1", 32'(bus.InFlightCount), 32'd1);
    check("t1_wbv_early", 32'(bus.WritebackValid), 32'd0);
    check("t1_alu_op", 32'(bus.AluMinorOpcode), 32'd0);
    check("t1_alu_b", 32'(bus.AluOperandBData), 32'h3);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_wbv", 32'(bus.WritebackValid), 32'd1);
    check("t1_wb_data", 32'(bus.WritebackData), 32'h0008);
    check("t1_wb_addr", 32'(bus.WritebackRegAddr), 32'd5);
    check("t1_inflight_s2", 32'(bus.InFlightCount), 32'd1);
    @(posedge clk); #1;
    bus.WritebackAck = 1'b1;
    @(negedge clk);
    check("t1_inflight_ack", 32'(bus.InFlightCount), 32'd1);
    @(posedge clk); #1;
    bus.WritebackAck = 1'b0;
    @(negedge clk);
    check("t1_inflight_done", 32'(bus.InFlightCount), 32'd0);
    check("t1_wbv_done", 32'(bus.WritebackValid), 32'd0);
    @(posedge clk); #1;

    // Back-to-back stream with constant ack
    bus.WritebackAck = 1'b1;
    base = retireCount;
    for (int i = 0; i < 8; i++) begin
      sendRandom(st);
      check("t2_no_stall", 32'(st), 32'd0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t2_retired", 32'(retireCount - base), 32'd8);
    check("t2_queue_empty", 32'(sbQ.size()), 32'd0);
    check("t2_inflight", 32'(bus.InFlightCount), 32'd0);

    // Back-pressure with ack low
    bus.WritebackAck = 1'b0;
    base = retireCount;
    sendRandom(st);
    check("t3_stall0", 32'(st), 32'd0);
    sendRandom(st);
    check("t3_stall1", 32'(st), 32'd0);
    bus.InstructionValid = 1'b1;
    @(negedge clk);
    check("t3_ready_low", 32'(bus.InstructionReady), 32'd0);
    check("t3_inflight", 32'(bus.InFlightCount), 32'd2);
    check("t3_wbv", 32'(bus.WritebackValid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_ready_still_low", 32'(bus.InstructionReady), 32'd0);
    @(posedge clk); #1;
    bus.WritebackAck = 1'b1;
    sendRandom(st);
    check("t3_third_accept", 32'(st), 32'd0);
    waitDrain(20);
    check("t3_retired", 32'(retireCount - base), 32'd3);

    // Register-0 destination is dropped
    base = retireCount;
    sendInstr(4'h4, 16'h1234, 16'h00ff, 4'd0, st);
    sendInstr(4'h1, 16'h0100, 16'h0001, 4'd7, st);
    waitDrain(20);
    check("t4_retired", 32'(retireCount - base), 32'd1);

    // Flush with both stages full
    bus.WritebackAck = 1'b0;
    sendRandom(st);
    sendRandom(st);
    bus.InstructionValid = 1'b1;
    bus.Flush = 1'b1;
    bus.WritebackAck = 1'b1;
    @(negedge clk);
    check("t5_ready_flush", 32'(bus.InstructionReady), 32'd0);
    check("t5_inflight_pre", 32'(bus.InFlightCount), 32'd2);
    @(posedge clk); #1;
    bus.Flush = 1'b0;
    bus.WritebackAck = 1'b0;
    bus.InstructionValid = 1'b0;
    @(negedge clk);
    check("t5_wbv", 32'(bus.WritebackValid), 32'd0);
    check("t5_inflight", 32'(bus.InFlightCount), 32'd0);
    check("t5_ready", 32'(bus.InstructionReady), 32'd1);
    @(posedge clk); #1;
    bus.WritebackAck = 1'b1;
    base = retireCount;
    sendRandom(st);
    waitDrain(20);
    check("t5_after_flush", 32'(retireCount - base), 32'd1);

    // Synchronous reset with both stages full
    bus.WritebackAck = 1'b0;
    sendRandom(st);
    sendRandom(st);
    sync_rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    sync_rst = 1'b0;
    @(negedge clk);
    check("t6_wbv", 32'(bus.WritebackValid), 32'd0);
    check("t6_inflight", 32'(bus.InFlightCount), 32'd0);
    check("t6_ready", 32'(bus.InstructionReady), 32'd1);
    check("t6_wb_data", 32'(bus.WritebackData), 32'd0);
    check("t6_alu_a", 32'(bus.AluOperandAData), 32'd0);
    @(posedge clk); #1;

    // Random traffic: random ack, occasional flush, random dispatcher gaps
    pending = 1'b0;
    rOp = '0; rA = '0; rB = '0; rD = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.WritebackAck = ($urandom_range(0, 3) != 0);
      bus.Flush = ($urandom_range(0, 40) == 0);
      if (!pending && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        rOp = 4'($urandom_range(0, 7));
        rA = DW'($urandom);
        rB = DW'($urandom);
        rD = RW'($urandom_range(0, 15));
      end
      bus.InstructionValid = pending;
      bus.MinorOpcode = rOp;
      bus.OperandAData = rA;
      bus.OperandBData = rB;
      bus.DestRegAddr = rD;
      @(negedge clk);
      if (pending && bus.InstructionReady && !sync_rst) begin
        if (rD != '0) sbQ.push_back('{rD, aluModel(rOp, rA, rB)});
        pending = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.InstructionValid = 1'b0;
    bus.Flush = 1'b0;
    bus.WritebackAck = 1'b1;
    waitDrain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
